// File: rtl/apb_bus_checker.sv
// Passive APB protocol checker. It tracks the setup/access phases of one bus
// segment and flags protocol violations as registered, sticky status. It also
// keeps saturating counts of completed reads and writes.
module apb_bus_checker #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 16,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SEL-1:0]    PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic                  PREADY,
  input  logic                  err_clr,
  output logic                  err_pulse,
  output logic [2:0]            err_code,
  output logic [5:0]            err_sticky,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  // The wait counter saturates at TIMEOUT, so the timeout condition is true on one edge only.
  localparam int WAIT_W = $clog2(TIMEOUT + 2);

  localparam logic [NUM_SEL-1:0]   SEL_ONE  = 1;
  localparam logic [WAIT_W-1:0]    WAIT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} phase_t;

  phase_t                phase_q, phase_d;
  logic                  arm_q, arm_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_SEL-1:0]    sel_q, sel_d;
  logic                  write_q, write_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [5:0]            new_err;
  logic                  wr_inc, rd_inc;
  logic                  access_eval;
  logic [2:0]            code_d;
  logic                  sel;

  // PRDATA is not checked. It is kept on the port list so the port widths match the bus.
  logic prdata_unused;
  assign prdata_unused = ^PRDATA;

  assign sel = |PSEL;

  // Violation detection and next-state logic for the phase tracker.
  always_comb begin
    phase_d     = phase_q;
    arm_d       = arm_q | ~sel;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sel_d       = sel_q;
    write_d     = write_q;
    wait_d      = wait_q;
    new_err     = '0;
    wr_inc      = 1'b0;
    rd_inc      = 1'b0;
    access_eval = 1'b0;
    if (arm_q) begin
      new_err[0] = |(PSEL & (PSEL - SEL_ONE));
      case (phase_q)
        IDLE: begin
          if (sel && !PENABLE) begin
            addr_d  = PADDR;
            wdata_d = PWDATA;
            sel_d   = PSEL;
            write_d = PWRITE;
            phase_d = SETUP;
          end else if (sel && PENABLE) begin
            new_err[1] = 1'b1;
          end
        end
        SETUP: begin
          if (!(sel && PENABLE)) begin
            new_err[2] = 1'b1;
            if (sel) begin
              // A new setup phase replaces the missing access phase.
              addr_d  = PADDR;
              wdata_d = PWDATA;
              sel_d   = PSEL;
              write_d = PWRITE;
            end else begin
              phase_d = IDLE;
            end
          end else begin
            access_eval = 1'b1;
          end
        end
        ACCESS:  access_eval = 1'b1;
        default: phase_d = IDLE;
      endcase

      if (access_eval) begin
        new_err[3] = (PADDR != addr_q) || (PWRITE != write_q) || (PSEL != sel_q) ||
                     (PWRITE && (PWDATA != wdata_q));
        if ((phase_q == ACCESS) && !(sel && PENABLE)) begin
          new_err[4] = 1'b1;
          wait_d     = '0;
          phase_d    = IDLE;
        end else if (PREADY) begin
          wr_inc  = PWRITE;
          rd_inc  = ~PWRITE;
          wait_d  = '0;
          phase_d = IDLE;
        end else begin
          phase_d = ACCESS;
          if (int'(wait_q) < TIMEOUT) wait_d = wait_q + WAIT_ONE;
          if ((TIMEOUT > 0) && (int'(wait_q) == TIMEOUT - 1)) new_err[5] = 1'b1;
        end
      end
    end
  end

  // Report the lowest-numbered violation found in this cycle.
  always_comb begin
    code_d = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (new_err[i]) code_d = 3'(i);
    end
  end

  // Phase tracker state and latched transfer attributes.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      phase_q <= IDLE;
      arm_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      write_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      phase_q <= phase_d;
      arm_q   <= arm_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      wait_q  <= wait_d;
    end
  end

  // Registered error status. When clear and set happen on the same edge, the set takes priority.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      err_pulse  <= 1'b0;
      err_code   <= 3'd0;
      err_sticky <= 6'd0;
      err_addr   <= '0;
    end else begin
      err_pulse  <= |new_err;
      err_sticky <= (err_clr ? 6'd0 : err_sticky) | new_err;
      if (|new_err) begin
        err_code <= code_d;
        err_addr <= (phase_q == IDLE) ? PADDR : addr_q;
      end
    end
  end

  // Saturating counts of completed transfers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_inc && (wr_count != '1)) wr_count <= wr_count + CNT_ONE;
      if (rd_inc && (rd_count != '1)) rd_count <= rd_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_apb_bus_checker.sv
// Directed bench for apb_bus_checker. The main instance uses TIMEOUT=4.
// A second instance with TIMEOUT=1 checks that the first wait state flags a timeout.
module tb_apb_bus_checker;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [15:0] PSEL;
  logic        PENABLE, PWRITE, PREADY, err_clr;

  logic        err_pulse;
  logic [2:0]  err_code;
  logic [5:0]  err_sticky;
  logic [31:0] err_addr;
  logic [15:0] wr_count, rd_count;

  logic        t1_err_pulse;
  logic [2:0]  t1_err_code;
  logic [5:0]  t1_err_sticky;
  logic [31:0] t1_err_addr;
  logic [15:0] t1_wr_count, t1_rd_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt;

  always #5 PCLK = ~PCLK;

  apb_bus_checker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(16), .TIMEOUT(4), .CNT_WIDTH(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PREADY(PREADY), .err_clr(err_clr),
    .err_pulse(err_pulse), .err_code(err_code), .err_sticky(err_sticky), .err_addr(err_addr),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  apb_bus_checker #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SEL(16), .TIMEOUT(1), .CNT_WIDTH(16)) dut_t1 (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PREADY(PREADY), .err_clr(err_clr),
    .err_pulse(t1_err_pulse), .err_code(t1_err_code), .err_sticky(t1_err_sticky), .err_addr(t1_err_addr),
    .wr_count(t1_wr_count), .rd_count(t1_rd_count)
  );

  task automatic cyc();
    @(posedge PCLK);
    #1;
    if (err_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic bus_idle();
    PSEL = '0; PENABLE = 1'b0; PREADY = 1'b0; PWRITE = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    PRESET = 1'b1; bus_idle(); cyc();
    PRESET = 1'b0; cyc();
    pulse_cnt = 0;
  endtask

  task automatic xfer(input logic [31:0] a, input logic w, input logic [15:0] s,
                      input logic [31:0] d, input int waits);
    PADDR = a; PWRITE = w; PSEL = s; PWDATA = d; PENABLE = 1'b0; PREADY = 1'b0;
    cyc();
    PENABLE = 1'b1;
    for (int i = 0; i < waits; i++) cyc();
    PREADY = 1'b1;
    cyc();
    bus_idle();
    cyc();
  endtask

  task automatic test_reset();
    PRESET = 1'b1; bus_idle(); PADDR = '0; PWDATA = '0; PRDATA = '0;
    cyc();
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%0h exp=0", err_pulse); end
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_code got=%0h exp=0", err_code); end
    n_tests++; if (err_sticky !== 6'd0) begin n_fail++; $display("FAIL reset_sticky got=%0h exp=0", err_sticky); end
    n_tests++; if (err_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got=%0h exp=0", err_addr); end
    n_tests++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL reset_wr got=%0d exp=0", wr_count); end
    n_tests++; if (rd_count !== 16'd0) begin n_fail++; $display("FAIL reset_rd got=%0d exp=0", rd_count); end
    $display("[TB] reset: pulse=%0h code=%0d sticky=%0h", err_pulse, err_code, err_sticky);
  endtask

  task automatic test_clean();
    do_reset();
    xfer(32'h10, 1'b1, 16'h0001, 32'hDEAD_BEEF, 0);
    xfer(32'h14, 1'b0, 16'h0001, 32'h0, 3);
    n_tests++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL clean_wr got=%0d exp=1", wr_count); end
    n_tests++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL clean_rd got=%0d exp=1", rd_count); end
    n_tests++; if (err_sticky !== 6'd0) begin n_fail++; $display("FAIL clean_sticky got=%0h exp=0", err_sticky); end
    n_tests++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL clean_pulses got=%0d exp=0", pulse_cnt); end
    $display("[TB] clean: wr=%0d rd=%0d pulses=%0d", wr_count, rd_count, pulse_cnt);
  endtask

  task automatic test_no_setup();
    do_reset();
    PADDR = 32'h30; PSEL = 16'h0004; PENABLE = 1'b1;
    cyc();
    n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL nosetup_pulse got=%0h exp=1", err_pulse); end
    n_tests++; if (err_code !== 3'd1) begin n_fail++; $display("FAIL nosetup_code got=%0d exp=1", err_code); end
    n_tests++; if (err_sticky !== 6'h02) begin n_fail++; $display("FAIL nosetup_sticky got=%0h exp=02", err_sticky); end
    n_tests++; if (err_addr !== 32'h30) begin n_fail++; $display("FAIL nosetup_addr got=%0h exp=30", err_addr); end
    bus_idle(); cyc();
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL nosetup_pulse_end got=%0h exp=0", err_pulse); end
    n_tests++; if (err_sticky !== 6'h02) begin n_fail++; $display("FAIL nosetup_hold got=%0h exp=02", err_sticky); end
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    n_tests++; if (err_sticky !== 6'h00) begin n_fail++; $display("FAIL nosetup_clr got=%0h exp=0", err_sticky); end
    $display("[TB] no_setup: code=%0d addr=%0h", err_code, err_addr);
  endtask

  task automatic test_unstable();
    do_reset();
    PADDR = 32'h20; PWRITE = 1'b1; PWDATA = 32'hA5A5_0001; PSEL = 16'h0001; PENABLE = 1'b0; PREADY = 1'b0;
    cyc();
    PENABLE = 1'b1;
    cyc();
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL unstable_early got=%0h exp=0", err_pulse); end
    PADDR = 32'h24;
    cyc();
    n_tests++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL unstable_pulse got=%0h exp=1", err_pulse); end
    n_tests++; if (err_code !== 3'd3) begin n_fail++; $display("FAIL unstable_code got=%0d exp=3", err_code); end
    n_tests++; if (err_addr !== 32'h20) begin n_fail++; $display("FAIL unstable_addr got=%0h exp=20", err_addr); end
    n_tests++; if (err_sticky !== 6'h08) begin n_fail++; $display("FAIL unstable_sticky got=%0h exp=08", err_sticky); end
    PREADY = 1'b1;
    cyc();
    bus_idle(); cyc();
    n_tests++; if (wr_count !== 16'd1) begin n_fail++; $display("FAIL unstable_wr got=%0d exp=1", wr_count); end
    $display("[TB] unstable: code=%0d addr=%0h wr=%0d", err_code, err_addr, wr_count);
  endtask

  task automatic test_timeout();
    int first_idx;
    do_reset();
    first_idx = -1;
    PADDR = 32'h44; PWRITE = 1'b0; PSEL = 16'h0002; PENABLE = 1'b0; PREADY = 1'b0;
    cyc();
    PENABLE = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (err_pulse === 1'b1 && first_idx < 0) first_idx = i;
      if (i == 1) begin
        n_tests++; if (t1_err_pulse !== 1'b1) begin n_fail++; $display("FAIL timeout1_first got=%0h exp=1", t1_err_pulse); end
        n_tests++; if (t1_err_code !== 3'd5) begin n_fail++; $display("FAIL timeout1_code got=%0d exp=5", t1_err_code); end
      end
    end
    PREADY = 1'b1; cyc();
    bus_idle(); cyc();
    n_tests++; if (pulse_cnt !== 1) begin n_fail++; $display("FAIL timeout_count got=%0d exp=1", pulse_cnt); end
    n_tests++; if (first_idx !== 4) begin n_fail++; $display("FAIL timeout_edge got=%0d exp=4", first_idx); end
    n_tests++; if (err_sticky !== 6'h20) begin n_fail++; $display("FAIL timeout_sticky got=%0h exp=20", err_sticky); end
    n_tests++; if (err_code !== 3'd5) begin n_fail++; $display("FAIL timeout_code got=%0d exp=5", err_code); end
    n_tests++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL timeout_rd got=%0d exp=1", rd_count); end
    n_tests++; if (t1_err_sticky !== 6'h20) begin n_fail++; $display("FAIL timeout1_sticky got=%0h exp=20", t1_err_sticky); end
    $display("[TB] timeout: pulses=%0d edge=%0d rd=%0d", pulse_cnt, first_idx, rd_count);
  endtask

  task automatic test_multi_clear();
    do_reset();
    PSEL = 16'h0001; PENABLE = 1'b1; cyc();
    bus_idle(); cyc();
    n_tests++; if (err_sticky !== 6'h02) begin n_fail++; $display("FAIL multi_pre got=%0h exp=02", err_sticky); end
    PADDR = 32'h50; PSEL = 16'h0003; PENABLE = 1'b0; PWRITE = 1'b0; err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    n_tests++; if (err_sticky !== 6'h01) begin n_fail++; $display("FAIL multi_setwins got=%0h exp=01", err_sticky); end
    n_tests++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL multi_code got=%0d exp=0", err_code); end
    n_tests++; if (err_addr !== 32'h50) begin n_fail++; $display("FAIL multi_addr got=%0h exp=50", err_addr); end
    PENABLE = 1'b1; PREADY = 1'b1; cyc();
    bus_idle(); err_clr = 1'b1; cyc(); err_clr = 1'b0;
    n_tests++; if (err_sticky !== 6'h00) begin n_fail++; $display("FAIL multi_clr got=%0h exp=0", err_sticky); end
    n_tests++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL multi_pulse_end got=%0h exp=0", err_pulse); end
    n_tests++; if (rd_count !== 16'd1) begin n_fail++; $display("FAIL multi_rd got=%0d exp=1", rd_count); end
    $display("[TB] multi_clear: sticky=%0h rd=%0d", err_sticky, rd_count);
  endtask

  task automatic test_abort();
    do_reset();
    PADDR = 32'h60; PWRITE = 1'b0; PSEL = 16'h0002; PENABLE = 1'b0; PREADY = 1'b0;
    cyc();
    PENABLE = 1'b1; cyc();
    PENABLE = 1'b0; cyc();
    n_tests++; if (err_code !== 3'd4) begin n_fail++; $display("FAIL abort_code got=%0d exp=4", err_code); end
    n_tests++; if (err_sticky !== 6'h10) begin n_fail++; $display("FAIL abort_sticky got=%0h exp=10", err_sticky); end
    bus_idle(); cyc();
    n_tests++; if (rd_count !== 16'd0) begin n_fail++; $display("FAIL abort_rd got=%0d exp=0", rd_count); end
    $display("[TB] abort: code=%0d sticky=%0h", err_code, err_sticky);
  endtask

  task automatic test_reset_mid();
    do_reset();
    PSEL = 16'h0001; PENABLE = 1'b1; cyc();
    bus_idle(); cyc();
    xfer(32'h40, 1'b1, 16'h0001, 32'h1234, 0);
    n_tests++; if (wr_count !== 16'd1 || err_sticky !== 6'h02) begin
      n_fail++; $display("FAIL rmid_pre got=wr%0d/%0h exp=wr1/02", wr_count, err_sticky);
    end
    PADDR = 32'h48; PWRITE = 1'b0; PSEL = 16'h0001; PENABLE = 1'b0; PREADY = 1'b0;
    cyc();
    PENABLE = 1'b1; cyc(); cyc();
    #2 PRESET = 1'b1;
    #1;
    n_tests++; if (wr_count !== 16'd0) begin n_fail++; $display("FAIL rmid_wr got=%0d exp=0", wr_count); end
    n_tests++; if (err_sticky !== 6'd0 || err_code !== 3'd0 || err_addr !== 32'd0) begin
      n_fail++; $display("FAIL rmid_err got=%0h/%0d/%0h exp=0/0/0", err_sticky, err_code, err_addr);
    end
    cyc();
    PRESET = 1'b0;
    pulse_cnt = 0;
    cyc(); cyc(); cyc();
    n_tests++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL rmid_unarmed got=%0d exp=0", pulse_cnt); end
    bus_idle(); cyc();
    PSEL = 16'h0001; PENABLE = 1'b1; cyc();
    n_tests++; if (err_pulse !== 1'b1 || err_code !== 3'd1) begin
      n_fail++; $display("FAIL rmid_resume got=%0h/%0d exp=1/1", err_pulse, err_code);
    end
    bus_idle(); cyc();
    $display("[TB] reset_mid: code=%0d sticky=%0h", err_code, err_sticky);
  endtask

  initial begin
    pulse_cnt = 0;
    test_reset();
    test_clean();
    test_no_setup();
    test_unstable();
    test_timeout();
    test_multi_clear();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_bus_checker.md
# apb_bus_checker

Synthesizable, parametrised APB protocol checker that passively samples one APB bus segment with NUM_SEL slave selects and flags protocol violations as registered, sticky status. It generalises our simulation-only PSEL X-check into a full setup/access phase tracker with stability, abort and wait-state timeout checks, plus read/write transfer counters. It sits beside the APB bridge, and its status feeds the debug register block and the emulation build.

## Interface
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width
- NUM_SEL, 16, number of PSEL lines (1..32)
- TIMEOUT, 16, max wait states per transfer; 0 disables the timeout check
- CNT_WIDTH, 16, transfer counter width
- PCLK  in  1  bus clock; all sampling on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PADDR  in  ADDR_WIDTH  address
- PWDATA  in  DATA_WIDTH  write data
- PRDATA  in  DATA_WIDTH  read data; not checked, carried for width consistency
- PSEL  in  NUM_SEL  slave selects
- PENABLE, PWRITE, PREADY  in  1 each  APB controls
- err_clr  in  1  clears err_sticky
- err_pulse  out  1  one-cycle pulse per cycle with any new violation
- err_code  out  3  lowest-numbered violation in the last flagged cycle
- err_sticky  out  6  accumulated violation bits [5:0]
- err_addr  out  ADDR_WIDTH  latched PADDR of the last flagged transfer
- wr_count, rd_count  out  CNT_WIDTH each  completed transfers, saturating

## Operation
- Phase FSM: IDLE, SETUP, ACCESS, plus an arm bit. After reset, arm=0 and all checks and counts are suppressed. arm is set at the first sampled edge with PSEL==0.
- sel = |PSEL.
- IDLE:
  - sel & !PENABLE: latch PADDR/PWRITE/PSEL/PWDATA, go to SETUP.
  - sel & PENABLE: raise E1 NO_SETUP, stay in IDLE. This also covers PENABLE held high on the edge after a completion.
- SETUP:
  - Requires sel & PENABLE; otherwise raise E2 NO_ACCESS.
  - If E2 fires with sel & !PENABLE: re-latch and stay in SETUP. If E2 fires with !sel: go to IDLE.
  - If valid: go to ACCESS evaluation in the same sample, described next.
- ACCESS evaluation, on every valid SETUP→access edge and every ACCESS edge:
  - E3 UNSTABLE if PADDR, PWRITE or PSEL differs from the latched value, or PWDATA differs while PWRITE=1.
  - E4 ABORT if !sel or !PENABLE while in ACCESS; go to IDLE, nothing counted.
  - PREADY=1 completes the transfer: increment wr_count or rd_count by PWRITE (saturating at all-ones), clear the wait counter, go to IDLE.
  - PREADY=0: increment the wait counter and stay in ACCESS. When the counter reaches TIMEOUT, raise E5 TIMEOUT once per transfer; tracking continues.
- E0 MULTI_SEL: more than one PSEL bit set at any armed edge, checked independently of phase.
- When a cycle flags any error:
  - err_sticky |= new bits.
  - err_code = lowest set new bit index.
  - err_addr = latched PADDR, or current PADDR in IDLE.
  - err_pulse = 1.
- err_clr: clears err_sticky. New errors on the same edge are still set, because set wins over clear. err_clr does not clear the counters.

## Timing
- Detection is combinational on sampled inputs and state. All outputs are registered, so they are visible one PCLK after the offending edge.
- err_pulse is high for exactly one cycle per flagged edge. Back-to-back violations give a continuous high.
- Counters update on the edge after the PREADY=1 sample.
- Reset values: err_pulse=0, err_code=0, err_sticky=0, err_addr=0, wr_count=0, rd_count=0, phase=IDLE, arm=0, wait counter=0.
- PRESET asserted mid-transfer clears everything immediately. A transfer in flight at release is ignored until the bus idles, because arm=0.
- With TIMEOUT=1, the first wait state flags E5.

## Test plan
- Clean traffic: write to 0x10 with 0 waits, then read from 0x14 with 3 waits, PSEL=0x0001 → wr_count=1, rd_count=1, err_sticky=0, err_pulse never high.
- No setup: PSEL=0x0004 and PENABLE=1 on the same first edge → err_pulse one cycle later, err_code=1, err_sticky=0x02.
- Instability: write, with PADDR changed from 0x20 to 0x24 during the second wait state → err_code=3, err_addr=0x20. Transfer still counts on PREADY: wr_count=1.
- Timeout: TIMEOUT=4, PREADY held low for 10 cycles → E5 flagged exactly once (err_sticky=0x20), then transfer completes with rd_count=1.
- Multi-select plus clear: PSEL=0x0003 in setup with err_clr pulsed on the same edge → err_sticky=0x01 (set wins). Next err_clr with no error → err_sticky=0.
- Reset mid-ACCESS: PRESET asserted during waits, released while PSEL/PENABLE are still high → all outputs 0. No E1 until the bus idles, after which normal checking resumes.
